factorial_mmio_slave: RTL and testbench

//  Responder end of the CPU-to-factorial-accelerator link on the picorv32 native memory bus.

---
 rtl/factorial_mmio_slave_pkg.sv | 39 +++
 rtl/factorial_engine.sv | 96 +++++++++
 rtl/factorial_mmio_slave.sv | 97 +++++++++
 tb/tb_factorial_mmio_slave.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/factorial_mmio_slave_pkg.sv
// Shared definitions for the factorial accelerator register window:
// register offsets, STATUS bit positions and engine state encodings.
package factorial_mmio_slave_pkg;

    // Byte offsets of the four registers inside the 16-byte window
    localparam logic [3:0] OFF_NUM  = 4'h0;
    localparam logic [3:0] OFF_CTRL = 4'h4;
    localparam logic [3:0] OFF_RES  = 4'h8;
    localparam logic [3:0] OFF_STAT = 4'hC;

    // STATUS register bit positions
    localparam int STAT_DONE = 0;
    localparam int STAT_BUSY = 1;
    localparam int STAT_OVF  = 2;

    // Factorial engine states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_t;

    // Word-aligned register offset; address bits [1:0] are don't-care
    function automatic logic [3:0] word_off(input logic [3:0] addr_lo);
        return {addr_lo[3:2], 2'b00};
    endfunction

    // Pack the STATUS register image
    function automatic logic [31:0] status_word(input logic done,
                                                input logic busy,
                                                input logic ovf);
        logic [31:0] w;
        w            = '0;
        w[STAT_DONE] = done;
        w[STAT_BUSY] = busy;
        w[STAT_OVF]  = ovf;
        return w;
    endfunction

endpackage

// File: rtl/factorial_engine.sv
// Sequential multiply-iterate factorial engine. A start in IDLE either
// flags overflow immediately (N > MAX_N) or loads acc=1, cnt=N and then
// multiplies acc by cnt once per cycle until cnt drops to 1.
module factorial_engine
    import factorial_mmio_slave_pkg::*;
#(
    parameter int MAX_N    = 20,
    parameter int RESULT_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    input  logic [31:0]         i_num,
    output logic [RESULT_W-1:0] o_result,
    output logic                o_done,
    output logic                o_busy,
    output logic                o_ovf
);

    state_t              r_state, w_state_nxt;
    logic [RESULT_W-1:0] r_acc, w_acc_nxt;
    logic [RESULT_W-1:0] r_result, w_result_nxt;
    logic [31:0]         r_cnt, w_cnt_nxt;
    logic                r_done, w_done_nxt;
    logic                r_ovf, w_ovf_nxt;
    logic [RESULT_W-1:0] w_prod;

    // Only the low RESULT_W bits of acc*cnt are kept; N <= MAX_N never wraps
    assign w_prod = r_acc * RESULT_W'(r_cnt);

    // Next-state and next-value logic; everything holds unless a branch updates it
    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;
        w_done_nxt   = r_done;
        w_ovf_nxt    = r_ovf;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_num > 32'(MAX_N)) begin
                        w_ovf_nxt    = 1'b1;
                        w_result_nxt = '0;
                        w_done_nxt   = 1'b1;
                    end else begin
                        w_acc_nxt   = RESULT_W'(1);
                        w_cnt_nxt   = i_num;
                        w_done_nxt  = 1'b0;
                        w_ovf_nxt   = 1'b0;
                        w_state_nxt = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                // cnt of 0 or 1 finishes straight away, so 0! = 1! = 1
                if (r_cnt <= 32'd1) begin
                    w_result_nxt = r_acc;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_acc_nxt = w_prod;
                    w_cnt_nxt = r_cnt - 32'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Control and visible result registers; reset aborts any computation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_result <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_result <= w_result_nxt;
            r_done   <= w_done_nxt;
            r_ovf    <= w_ovf_nxt;
        end
    end

    // Working accumulator and counter; always reloaded before use, so no reset
    always_ff @(posedge clk) begin
        r_acc <= w_acc_nxt;
        r_cnt <= w_cnt_nxt;
    end

    assign o_result = r_result;
    assign o_done   = r_done;
    assign o_busy   = (r_state == ST_CALC);
    assign o_ovf    = r_ovf;

endmodule

// File: rtl/factorial_mmio_slave.sv
// picorv32 native-bus responder for the factorial accelerator. Decodes a
// 16-byte window, acknowledges each hit with a one-cycle mem_ready, holds
// the operand register and wraps the factorial engine.
module factorial_mmio_slave
    import factorial_mmio_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0FFF_FFF0,
    parameter int          MAX_N     = 20,
    parameter int          RESULT_W  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        irq
);

    logic                r_ready;
    logic [31:0]         r_rdata;
    logic [31:0]         r_num;
    logic                w_hit;
    logic                w_write;
    logic [3:0]          w_off;
    logic                w_start;
    logic                w_num_we;
    logic [31:0]         w_rdata_nxt;
    logic [RESULT_W-1:0] w_result;
    logic                w_done;
    logic                w_busy;
    logic                w_ovf;
    logic                w_unused;

    // The !r_ready term stops the held request from being taken twice
    assign w_hit    = mem_valid && !r_ready && (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign w_write  = |mem_wstrb;
    assign w_off    = word_off(mem_addr[3:0]);
    assign w_start  = w_hit && w_write && (w_off == OFF_CTRL) && mem_wstrb[0] && mem_wdata[0];
    // Operand is frozen while the engine is busy
    assign w_num_we = w_hit && w_write && (w_off == OFF_NUM) && !w_busy;
    assign w_unused = &{1'b0, mem_addr[1:0]};

    // Read data selection from pre-edge register values (RES_HI is result[63:32])
    always_comb begin
        w_rdata_nxt = '0;
        case (w_off)
            OFF_NUM:  w_rdata_nxt = r_num;
            OFF_CTRL: w_rdata_nxt = w_result[63:32];
            OFF_RES:  w_rdata_nxt = w_result[31:0];
            OFF_STAT: w_rdata_nxt = status_word(w_done, w_busy, w_ovf);
            default:  w_rdata_nxt = '0;
        endcase
    end

    // Bus acknowledge, read data capture and byte-strobed operand writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_num   <= '0;
        end else begin
            r_ready <= w_hit;
            if (w_hit && !w_write) begin
                r_rdata <= w_rdata_nxt;
            end
            if (w_num_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wstrb[b]) begin
                        r_num[8*b +: 8] <= mem_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    factorial_engine #(
        .MAX_N    (MAX_N),
        .RESULT_W (RESULT_W)
    ) u_engine (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_start),
        .i_num    (r_num),
        .o_result (w_result),
        .o_done   (w_done),
        .o_busy   (w_busy),
        .o_ovf    (w_ovf)
    );

    assign mem_ready = r_ready;
    assign mem_rdata = r_rdata;
    assign irq       = w_done;

endmodule

// File: tb/tb_factorial_mmio_slave.sv
// Directed bench for the factorial MMIO responder.
module tb_factorial_mmio_slave;

    localparam logic [31:0] BASE = 32'h0FFF_FFF0;
    localparam logic [31:0] A_NUM  = BASE + 32'h0;
    localparam logic [31:0] A_CTRL = BASE + 32'h4;
    localparam logic [31:0] A_RES  = BASE + 32'h8;
    localparam logic [31:0] A_STAT = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        irq;

    int n_cmp  = 0;
    int n_fail = 0;

    factorial_mmio_slave dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the bus idle
    task automatic bus(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, output logic [31:0] rdata,
                       output logic acked);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        acked     = 1'b0;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(posedge clk);
            #1;
            if (mem_ready) acked = 1'b1;
        end
        rdata = mem_rdata;
        @(negedge clk);
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] d;
        logic        a;
        bus(addr, data, strb, d, a);
        chk("wr_ack", a, 1);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        logic a;
        bus(addr, 32'h0, 4'h0, data, a);
        chk("rd_ack", a, 1);
    endtask

    task automatic wait_done();
        logic [31:0] s;
        logic        seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            rd(A_STAT, s);
            if (s[0]) seen = 1'b1;
        end
        chk("done_wait", seen, 1);
    endtask

    initial begin
        logic [31:0] d;
        logic        a;

        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", mem_ready, 0);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_irq", irq, 0);
        @(negedge clk);
        reset = 1'b0;

        // STATUS read: ready one cycle after valid, for exactly one cycle
        mem_valid = 1'b1;
        mem_addr  = A_STAT;
        @(posedge clk);
        #1;
        chk("t1_ready_first", mem_ready, 1);
        chk("t1_status", mem_rdata, 0);
        @(posedge clk);
        #1;
        chk("t1_ready_one_cycle", mem_ready, 0);
        @(negedge clk);
        mem_valid = 1'b0;

        // Byte strobes on NUM
        wr(A_NUM, 32'hAABB_CCDD, 4'hF);
        wr(A_NUM, 32'h0000_1100, 4'b0010);
        rd(A_NUM, d);
        chk("num_bytestrobe", d, 32'hAABB_11DD);

        // START needs wstrb[0]
        wr(A_CTRL, 32'h1, 4'b0010);
        rd(A_STAT, d);
        chk("ctrl_no_start", d, 0);

        // N=5: done first visible after edge t+5
        wr(A_NUM, 32'd5, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        repeat (4) @(posedge clk);
        #1;
        chk("n5_irq_early", irq, 0);
        @(posedge clk);
        #1;
        chk("n5_irq_on_time", irq, 1);
        @(negedge clk);
        rd(A_STAT, d);
        chk("n5_status", d, 32'h1);
        rd(A_RES, d);
        chk("n5_res_lo", d, 32'd120);
        rd(A_CTRL, d);
        chk("n5_res_hi", d, 32'h0);

        // N=20: largest in range
        wr(A_NUM, 32'd20, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        wait_done();
        rd(A_CTRL, d);
        chk("n20_res_hi", d, 32'h21C3_677C);
        rd(A_RES, d);
        chk("n20_res_lo", d, 32'h82B4_0000);
        rd(A_STAT, d);
        chk("n20_status", d, 32'h1);

        // N=21: overflow flagged immediately
        wr(A_NUM, 32'd21, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        chk("n21_irq", irq, 1);
        rd(A_STAT, d);
        chk("n21_status", d, 32'h5);
        rd(A_RES, d);
        chk("n21_res_lo", d, 32'h0);
        rd(A_CTRL, d);
        chk("n21_res_hi", d, 32'h0);

        // N=0 gives 1 and clears ovf
        wr(A_NUM, 32'd0, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        wait_done();
        rd(A_RES, d);
        chk("n0_res_lo", d, 32'd1);
        rd(A_STAT, d);
        chk("n0_status", d, 32'h1);

        // N=2: STATUS sampled on the edge that sets done shows busy, not done
        wr(A_NUM, 32'd2, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        rd(A_STAT, d);
        chk("n2_status_preedge", d, 32'h2);
        rd(A_STAT, d);
        chk("n2_status_after", d, 32'h1);
        rd(A_RES, d);
        chk("n2_res_lo", d, 32'd2);

        // N=10 with NUM write and START while busy
        wr(A_NUM, 32'd10, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        wr(A_NUM, 32'd3, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        rd(A_RES, d);
        chk("n10_res_while_busy", d, 32'd2);
        rd(A_STAT, d);
        chk("n10_status_busy", d, 32'h2);
        wait_done();
        rd(A_RES, d);
        chk("n10_res_lo", d, 32'd3628800);
        rd(A_NUM, d);
        chk("n10_num_frozen", d, 32'd10);
        rd(A_CTRL, d);
        chk("n10_res_hi", d, 32'h0);

        // Reset in the middle of a computation
        wr(A_CTRL, 32'h1, 4'hF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_irq", irq, 0);
        chk("midrst_rdata", mem_rdata, 0);
        chk("midrst_ready", mem_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        rd(A_STAT, d);
        chk("midrst_status", d, 32'h0);
        rd(A_NUM, d);
        chk("midrst_num", d, 32'h0);
        rd(A_RES, d);
        chk("midrst_res_lo", d, 32'h0);
        repeat (15) @(posedge clk);
        #1;
        chk("midrst_no_done", irq, 0);
        @(negedge clk);

        // Misses never get ready
        bus(32'h0FFF_FFE0, 32'h0, 4'h0, d, a);
        chk("miss_below", a, 0);
        bus(32'h1000_0000, 32'h0, 4'h0, d, a);
        chk("miss_above", a, 0);

        // RES_LO write is acked and ignored; addr[1:0] ignored on decode
        wr(A_NUM, 32'd3, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        wait_done();
        wr(A_RES, 32'hDEAD_BEEF, 4'hF);
        rd(A_RES, d);
        chk("res_lo_write_ignored", d, 32'd6);
        rd(BASE + 32'hB, d);
        chk("addr_lsb_ignored", d, 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
